// File: rtl/deck_shuffle_ctrl.sv
// deck_shuffle_ctrl
// Sequences a full shuffle of the deck RAM. First an init pass writes card k
// to address k. Then, for each index i, the swap partner j is taken from the
// Nxt_Addr datapath and deck[i] and deck[j] are exchanged through a
// single-port RAM with a one-cycle synchronous read.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for i_Start, all RAM outputs quiet
// INIT   | write card k to address k, k = 0..DECK_SIZE-1
// RD_I   | present address i, freeze the swap partner into r_j
// RD_J   | present address r_j, capture deck[i] into tmp
// WR_I   | write deck[j] (arriving on the read port) to address i
// WR_J   | write tmp to address r_j, advance i or finish
// DONE   | one-cycle completion pulse

module deck_shuffle_ctrl #(
   parameter int DECK_SIZE = 52,
   parameter int ADDR_W    = 6
) (
   input  logic              clk_2K,
   input  logic              i_Reset,
   input  logic              i_Start,
   output logic              o_Busy,
   output logic              o_Done,
   output logic [ADDR_W-1:0] o_Addr_i,
   input  logic [ADDR_W-1:0] i_Addr_j,
   output logic [ADDR_W-1:0] o_MemAddr,
   output logic              o_MemWe,
   output logic [ADDR_W-1:0] o_MemWData,
   input  logic [ADDR_W-1:0] i_MemRData
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_RD_I = 3'd2,
      S_RD_J = 3'd3,
      S_WR_I = 3'd4,
      S_WR_J = 3'd5,
      S_DONE = 3'd6
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] k;
   logic [ADDR_W-1:0] i_q;
   logic [ADDR_W-1:0] r_j;
   logic [ADDR_W-1:0] tmp;
   logic [ADDR_W-1:0] wdata_q;
   logic              j_ok;
   logic [ADDR_W-1:0] j_sel;

   // A partner outside the deck cannot come from Nxt_Addr; if it ever does,
   // degrade to a self-swap so the deck stays a permutation.
   always_comb begin
      j_ok  = ({1'b0, i_Addr_j} < (ADDR_W+1)'(DECK_SIZE));
      j_sel = j_ok ? i_Addr_j : i_q;
   end

   // Sequencer: state, indices and registered RAM/handshake outputs.
   always_ff @(posedge clk_2K) begin
      if (!i_Reset) begin
         state     <= S_IDLE;
         k         <= '0;
         i_q       <= '0;
         r_j       <= '0;
         tmp       <= '0;
         wdata_q   <= '0;
         o_MemAddr <= '0;
         o_MemWe   <= 1'b0;
         o_Busy    <= 1'b0;
         o_Done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               o_Done <= 1'b0;
               i_q    <= '0;
               if (i_Start) begin
                  state     <= S_INIT;
                  k         <= '0;
                  o_MemAddr <= '0;
                  wdata_q   <= '0;
                  o_MemWe   <= 1'b1;
                  o_Busy    <= 1'b1;
               end else begin
                  o_MemAddr <= '0;
                  wdata_q   <= '0;
                  o_MemWe   <= 1'b0;
                  o_Busy    <= 1'b0;
               end
            end

            S_INIT: begin
               if (k == LAST) begin
                  state     <= S_RD_I;
                  i_q       <= '0;
                  o_MemAddr <= '0;
                  wdata_q   <= '0;
                  o_MemWe   <= 1'b0;
               end else begin
                  k         <= k + ADDR_W'(1);
                  o_MemAddr <= k + ADDR_W'(1);
                  wdata_q   <= k + ADDR_W'(1);
                  o_MemWe   <= 1'b1;
               end
            end

            S_RD_I: begin
               state     <= S_RD_J;
               r_j       <= j_sel;
               o_MemAddr <= j_sel;
               o_MemWe   <= 1'b0;
            end

            S_RD_J: begin
               state     <= S_WR_I;
               tmp       <= i_MemRData;
               o_MemAddr <= i_q;
               o_MemWe   <= 1'b1;
            end

            S_WR_I: begin
               state     <= S_WR_J;
               o_MemAddr <= r_j;
               wdata_q   <= tmp;
               o_MemWe   <= 1'b1;
            end

            S_WR_J: begin
               wdata_q <= '0;
               o_MemWe <= 1'b0;
               if (i_q == LAST) begin
                  state     <= S_DONE;
                  i_q       <= '0;
                  o_MemAddr <= '0;
                  o_Done    <= 1'b1;
               end else begin
                  state     <= S_RD_I;
                  i_q       <= i_q + ADDR_W'(1);
                  o_MemAddr <= i_q + ADDR_W'(1);
               end
            end

            S_DONE: begin
               state     <= S_IDLE;
               o_Done    <= 1'b0;
               o_Busy    <= 1'b0;
               o_MemAddr <= '0;
               wdata_q   <= '0;
               o_MemWe   <= 1'b0;
            end

            default: begin
               state     <= S_IDLE;
               k         <= '0;
               i_q       <= '0;
               o_Done    <= 1'b0;
               o_Busy    <= 1'b0;
               o_MemAddr <= '0;
               wdata_q   <= '0;
               o_MemWe   <= 1'b0;
            end
         endcase
      end
   end

   // deck[j] only appears on the read port during WR_I, so it is forwarded
   // straight through; every other write value comes from wdata_q.
   always_comb begin
      o_MemWData = (state == S_WR_I) ? i_MemRData : wdata_q;
      o_Addr_i   = i_q;
   end

endmodule

// File: tb/tb_deck_shuffle_ctrl.sv
// tb_deck_shuffle_ctrl
// Drives deck_shuffle_ctrl with a behavioural single-port RAM and a
// free-running 12-bit counter as the partner source, and compares every
// cycle of the RAM bus against a software deck model.

module tb_deck_shuffle_ctrl;

   localparam int DS      = 52;
   localparam int AW      = 6;
   localparam int ABORT_C = DS + 4*20 + 2;

   logic          clk = 1'b0;
   logic          i_reset;
   logic          i_start;
   logic          busy;
   logic          done;
   logic [AW-1:0] addr_i;
   logic [AW-1:0] i_addr_j;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [AW-1:0] mem_wdata;
   logic [AW-1:0] mem_rdata;

   logic [AW-1:0] mem [0:63];
   logic [11:0]   cnt = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   deck_shuffle_ctrl #(.DECK_SIZE(DS), .ADDR_W(AW)) dut (
      .clk_2K     (clk),
      .i_Reset    (i_reset),
      .i_Start    (i_start),
      .o_Busy     (busy),
      .o_Done     (done),
      .o_Addr_i   (addr_i),
      .i_Addr_j   (i_addr_j),
      .o_MemAddr  (mem_addr),
      .o_MemWe    (mem_we),
      .o_MemWData (mem_wdata),
      .i_MemRData (mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
      cnt <= cnt + 12'd1;
   end

   function automatic logic [31:0] pk(input bit b, input bit d, input bit w,
                                      input int a, input int wd, input int ai);
      return 32'({b, d, w, 6'(a), 6'(wd), 6'(ai)});
   endfunction

   function automatic logic [31:0] obs_v();
      return 32'({busy, done, mem_we, mem_addr, mem_wdata, addr_i});
   endfunction

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e, input logic [31:0] m);
      total++;
      assert ((o & m) === (e & m)) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o & m, e & m);
      end
   endtask

   // mode 0: counter-derived partner, mode 1: partner 5 (self at i=7),
   // mode 2: uniform random partner; modes 0/2 occasionally inject j >= DS.
   task automatic run_shuffle(input int mode, input bit pre, input bit abort20,
                              input bit poke, input bit hold);
      int deck [DS];
      int ii, ph, jj, jdrv, off, t, seen;
      logic [31:0] exp_v, msk;
      string tag;
      for (int n = 0; n < DS; n++) deck[n] = n;
      jj  = 0;
      off = int'($urandom_range(0, 4095));
      if (!pre) begin
         @(negedge clk);
         i_start = 1'b1;
      end
      for (int c = 0; c <= DS + 4*DS + 1; c++) begin
         @(negedge clk);
         msk = 32'h001F_FFFF;
         ii  = 0;
         ph  = 0;
         if (abort20 && c == ABORT_C + 1) begin
            chk("abort_idle", obs_v(), pk(0, 0, 0, 0, 0, 0), msk);
            i_reset = 1'b1;
            i_start = 1'b0;
            return;
         end
         if (c < DS) begin
            exp_v = pk(1, 0, 1, c, c, 0);
            tag   = "init";
         end else if (c < DS + 4*DS) begin
            ii = (c - DS) / 4;
            ph = (c - DS) % 4;
            case (ph)
               0: begin exp_v = pk(1, 0, 0, ii, 0, ii); msk[11:6] = '0; tag = "rd_i"; end
               1: begin exp_v = pk(1, 0, 0, jj, 0, ii); msk[11:6] = '0; tag = "rd_j"; end
               2: begin exp_v = pk(1, 0, 1, ii, deck[jj], ii); tag = "wr_i"; end
               default: begin exp_v = pk(1, 0, 1, jj, deck[ii], ii); tag = "wr_j"; end
            endcase
         end else if (c == DS + 4*DS) begin
            exp_v = pk(1, 1, 0, 0, 0, 0);
            tag   = "done";
         end else begin
            exp_v = pk(0, 0, 0, 0, 0, 0);
            tag   = "idle_after";
         end
         chk(tag, obs_v(), exp_v, msk);
         if (c >= DS && c < DS + 4*DS && ph == 3) begin
            t = deck[ii]; deck[ii] = deck[jj]; deck[jj] = t;
         end
         i_start = (poke && c == 100) || (hold && c >= DS + 4*DS - 5);
         if (abort20 && c == ABORT_C) i_reset = 1'b0;
         if (mode == 0) jdrv = (int'(cnt) + off) % DS;
         else           jdrv = int'($urandom_range(0, 63));
         if (c >= DS && c < DS + 4*DS && ph == 0) begin
            case (mode)
               0: if ($urandom_range(0, 7) == 0) jdrv = int'($urandom_range(DS, 63));
               1: jdrv = (ii == 7) ? 7 : 5;
               default: begin
                  if ($urandom_range(0, 5) == 0) jdrv = int'($urandom_range(DS, 63));
                  else                           jdrv = int'($urandom_range(0, DS-1));
               end
            endcase
            jj = (jdrv >= DS) ? ii : jdrv;
         end
         i_addr_j = 6'(jdrv);
      end
      for (int n = 0; n < DS; n++) chk("deck", 32'(mem[n]), 32'(deck[n]), 32'h3F);
      seen = 0;
      for (int v = 0; v < DS; v++) begin
         t = 0;
         for (int n = 0; n < DS; n++) if (int'(mem[n]) == v) t++;
         if (t == 1) seen++;
      end
      chk("perm", 32'(seen), 32'(DS), 32'hFFFF_FFFF);
      if (mode == 1) chk("deck5", 32'(mem[5]), 32'(DS - 1), 32'h3F);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      i_reset  = 1'b0;
      i_start  = 1'b1;
      i_addr_j = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset", obs_v(), pk(0, 0, 0, 0, 0, 0), 32'h001F_FFFF);
      i_reset = 1'b1;
      i_start = 1'b0;
      @(negedge clk);
      chk("reset_idle", obs_v(), pk(0, 0, 0, 0, 0, 0), 32'h001F_FFFF);

      run_shuffle(0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_shuffle(1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_shuffle(2, 1'b0, 1'b0, 1'b1, 1'b0);
      run_shuffle(0, 1'b0, 1'b1, 1'b0, 1'b0);
      run_shuffle(2, 1'b0, 1'b0, 1'b0, 1'b0);
      run_shuffle(2, 1'b0, 1'b0, 1'b0, 1'b1);
      run_shuffle(0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
